// File: rtl/path_sequencer_pkg.sv
// Shared types for the path sequencer and the line follower: turn/heading codes, FSM states,
// and the path-table entry layout.
package path_sequencer_pkg;

  localparam int PATH_DEPTH = 16;
  localparam int NODE_W     = 5;

  typedef enum logic [1:0] {
    TURN_FWD   = 2'd0,
    TURN_RIGHT = 2'd1,
    TURN_LEFT  = 2'd2,
    TURN_UTURN = 2'd3
  } turn_t;

  typedef enum logic [1:0] {
    HEAD_N = 2'd0,
    HEAD_E = 2'd1,
    HEAD_S = 2'd2,
    HEAD_W = 2'd3
  } head_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_TURN    = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    head_t             head;
  } path_entry_t;

  // Headings are quarter turns clockwise, so the 2-bit wrapped difference is the turn.
  function automatic turn_t turn_for(input head_t h_in, input head_t h_out);
    logic [1:0] d;
    turn_t      t;
    d = h_out - h_in;
    unique case (d)
      2'd0:    t = TURN_FWD;
      2'd1:    t = TURN_RIGHT;
      2'd2:    t = TURN_UTURN;
      default: t = TURN_LEFT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/path_table.sv
// Path table: DEPTH entries of {node, head}; one write port, two combinational read ports.
// Latency: write visible the cycle after wr_vld; reads are combinational.
// Backpressure: none; every write strobe presented is taken.
module path_table
  import path_sequencer_pkg::*;
#(
  parameter int DEPTH = PATH_DEPTH
) (
  input  logic                     clk_50M,
  input  logic                     wr_vld,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  path_entry_t              wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd0_idx,
  output path_entry_t              rd0_dat,
  input  logic [$clog2(DEPTH)-1:0] rd1_idx,
  output path_entry_t              rd1_dat
);

  // Contents deliberately survive reset so a path can be re-run after an abort.
  path_entry_t mem [DEPTH];

  always_ff @(posedge clk_50M) begin
    if (wr_vld) mem[wr_idx] <= wr_dat;
  end

  assign rd0_dat = mem[rd0_idx];
  assign rd1_dat = mem[rd1_idx];

endmodule

// File: rtl/path_sequencer.sv
// Walks a pre-loaded node path: counts node crossings, issues timed turns, masks re-detection.
// Latency: node_sig to turn_active is two cycles (input register + edge register).
// Backpressure: none; node edges outside RUN are dropped, table writes outside IDLE/DONE are dropped.
module path_sequencer
  import path_sequencer_pkg::*;
#(
  parameter int          DEPTH          = PATH_DEPTH,
  parameter int unsigned TURN_CYCLES    = 30_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 312_500_000
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cfg_wr,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [NODE_W-1:0]        cfg_node,
  input  logic [1:0]               cfg_head,
  input  logic [$clog2(DEPTH)-1:0] cfg_len,
  input  logic                     node_sig,
  output logic [1:0]               turn_cmd,
  output logic                     turn_active,
  output logic                     drive_en,
  output logic [$clog2(DEPTH)-1:0] node_idx,
  output logic [NODE_W-1:0]        current_node,
  output logic [NODE_W-1:0]        next_node,
  output logic                     complete
);

  localparam int IW = $clog2(DEPTH);

  state_t        state, state_nxt;
  logic [31:0]   timer;
  logic [IW-1:0] len;
  logic          node_q, node_q_d, node_edge;
  logic          turn_done, hold_done, tbl_wr_vld;
  path_entry_t   cur_ent, nxt_ent, wr_ent;

  assign node_edge  = node_q & ~node_q_d;
  assign turn_done  = (timer == 32'(TURN_CYCLES - 1));
  assign hold_done  = (timer == 32'(HOLDOFF_CYCLES - 1));
  assign tbl_wr_vld = cfg_wr & ((state == ST_IDLE) | (state == ST_DONE));
  assign wr_ent     = '{node: cfg_node, head: head_t'(cfg_head)};

  path_table #(.DEPTH(DEPTH)) u_table (
    .clk_50M (clk_50M),
    .wr_vld  (tbl_wr_vld),
    .wr_idx  (cfg_idx),
    .wr_dat  (wr_ent),
    .rd0_idx (node_idx),
    .rd0_dat (cur_ent),
    .rd1_idx (IW'(node_idx + 1'b1)),
    .rd1_dat (nxt_ent)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (!start)    state_nxt = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:     if (node_edge) state_nxt = ST_TURN;
      ST_TURN:    if (turn_done) state_nxt = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_done) state_nxt = (node_idx == len) ? ST_DONE : ST_RUN;
      default:                   state_nxt = ST_DONE;
    endcase
  end

  // The timer runs straight through TURN into HOLDOFF so the hold-off is measured from node entry.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      node_q   <= 1'b0;
      node_q_d <= 1'b0;
      timer    <= '0;
      len      <= '0;
      node_idx <= '0;
      turn_cmd <= TURN_FWD;
    end else begin
      node_q   <= node_sig;
      node_q_d <= node_q;
      if ((state_nxt == ST_TURN || state_nxt == ST_HOLDOFF) && state != ST_RUN)
        timer <= timer + 32'd1;
      else
        timer <= '0;
      if (state == ST_IDLE && !start) begin
        len      <= cfg_len;
        node_idx <= '0;
      end
      if (state == ST_RUN && node_edge) begin
        node_idx <= node_idx + 1'b1;
        turn_cmd <= turn_for(cur_ent.head, nxt_ent.head);
      end
    end
  end

  always_comb begin
    turn_active  = (state == ST_TURN);
    drive_en     = (state == ST_RUN) || (state == ST_TURN) || (state == ST_HOLDOFF);
    complete     = (state == ST_DONE);
    current_node = '0;
    next_node    = '0;
    if (state != ST_IDLE) begin
      current_node = cur_ent.node;
      next_node    = (node_idx == len) ? cur_ent.node : nxt_ent.node;
    end
  end

endmodule
